// File: rtl/accum_stream_packer.sv
// Packs one-cycle accumulator results into a framed 64-bit AXI4-Stream with seq tag and tlast.
// Latency: 1 clk from valid_in to m_axis_tvalid when the FIFO is empty; 1 word/clk sustained.
// Backpressure: absorbs up to FIFO_DEPTH words; further results are dropped and counted.
module accum_stream_packer #(
  parameter int FIFO_DEPTH = 16,
  parameter int FLEN_WIDTH = 16,
  parameter int SEQ_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic [47:0]           data_in,
  input  logic [FLEN_WIDTH-1:0] frame_len,
  output logic [63:0]           m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  overflow,
  output logic [15:0]           drop_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int DW = 64 - SEQ_WIDTH;

  typedef struct packed {
    logic        last;
    logic [63:0] tdata;
  } entry_t;

  // Storage and occupancy; count includes the word currently presented at the head.
  entry_t                mem_q [FIFO_DEPTH];
  logic [CW-1:0]         count_q, count_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;

  // Framing state.
  logic [FLEN_WIDTH-1:0] beat_q, beat_d;
  logic [SEQ_WIDTH-1:0]  seq_q, seq_d;
  logic [FLEN_WIDTH-1:0] flen_q, flen_d;

  // Registered stream outputs.
  logic                  tvalid_q, tvalid_d;
  logic                  tlast_q, tlast_d;
  logic [63:0]           tdata_q, tdata_d;

  // Drop reporting.
  logic                  overflow_q, overflow_d;
  logic [15:0]           drop_q, drop_d;

  // Per-cycle decisions.
  logic                  pop;
  logic                  push;
  logic                  drop;
  logic                  full;
  logic                  flen_chg;
  logic [FLEN_WIDTH-1:0] beat_cur;
  logic [FLEN_WIDTH-1:0] eff_len_m1;
  logic                  last_flag;
  logic [CW-1:0]         remain;
  entry_t                new_entry;
  entry_t                head;

  // Handshake, acceptance and frame tagging of the incoming result.
  always_comb begin
    pop        = tvalid_q & m_axis_tready;
    full       = (count_q == CW'(FIFO_DEPTH));
    push       = valid_in & (~full | pop);
    drop       = valid_in & ~push;

    flen_chg   = (frame_len != flen_q);
    beat_cur   = flen_chg ? '0 : beat_q;
    eff_len_m1 = (frame_len == '0) ? '0 : (frame_len - FLEN_WIDTH'(1));
    last_flag  = (beat_cur == eff_len_m1);

    new_entry.last  = last_flag;
    new_entry.tdata = {seq_q, DW'(signed'(data_in))};
  end

  // Next-state for pointers, count, framing counters and drop statistics.
  always_comb begin
    flen_d   = frame_len;
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);

    beat_d = beat_cur;
    seq_d  = seq_q;
    if (push) begin
      if (last_flag) begin
        beat_d = '0;
        seq_d  = seq_q + SEQ_WIDTH'(1);
      end else begin
        beat_d = beat_cur + FLEN_WIDTH'(1);
      end
    end

    overflow_d = overflow_q | drop;
    drop_d     = drop_q;
    if (drop && (drop_q != 16'hFFFF)) begin
      drop_d = drop_q + 16'd1;
    end
  end

  // Next head word: a push into an otherwise empty FIFO bypasses storage so tvalid
  // rises one cycle after valid_in; otherwise the head is read from storage, which is
  // already written because it is older than any same-cycle push.
  always_comb begin
    remain = count_q - CW'(pop);
    head   = mem_q[rd_ptr_d];
    if ((remain == '0) && push) begin
      head = new_entry;
    end

    tvalid_d = (count_d != '0);
    tdata_d  = tdata_q;
    tlast_d  = tlast_q;
    if (count_d != '0) begin
      tdata_d = head.tdata;
      tlast_d = head.last;
    end
  end

  // Control and output registers with synchronous reset; reset discards buffered words.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      beat_q     <= '0;
      seq_q      <= '0;
      flen_q     <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      tdata_q    <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      beat_q     <= beat_d;
      seq_q      <= seq_d;
      flen_q     <= flen_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      tdata_q    <= tdata_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  // Storage array write; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_q[wr_ptr_q] <= new_entry;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign overflow      = overflow_q;
  assign drop_count    = drop_q;

endmodule
